// File: rtl/thermal_palette_pkg.sv
// Shared widths and colour-mode encodings for the thermal palette mapper.
package thermal_palette_pkg;

    localparam int ADC_WIDHT = 12;
    localparam int VGA_WIDHT = 6;
    localparam int MODE_AUTO = 2;

    typedef enum logic [1:0] {
        MODE_GRAY = 2'b00,
        MODE_INV  = 2'b01,
        MODE_PAL  = 2'b10,
        MODE_TEST = 2'b11
    } colour_mode_e;

endpackage

// File: rtl/thermal_palette_ram.sv
// Simple dual-port palette store: one write port, one registered read port.
module thermal_palette_ram #(
    parameter int AW = 8,
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    // Read-before-write: a colliding read returns the previous entry.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/thermal_palette.sv
// ADC pixel to RGB mapper: frame-statistics contrast stretch, then gray /
// inverted / palette / test-red colouring. Fixed three-cycle latency.
module thermal_palette
    import thermal_palette_pkg::*;
#(
    parameter int ADC_W  = ADC_WIDHT,
    parameter int VGA_W  = VGA_WIDHT,
    parameter int LUT_AW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADC_W-1:0]     data_in,
    input  logic                 data_valid,
    input  logic                 frame_start,
    input  logic [2:0]           mode,
    input  logic                 pal_we,
    input  logic [LUT_AW-1:0]    pal_addr,
    input  logic [3*VGA_W-1:0]   pal_data,
    output logic [VGA_W-1:0]     red,
    output logic [VGA_W-1:0]     green,
    output logic [VGA_W-1:0]     blue,
    output logic                 out_valid
);

    function automatic int lead_one(input logic [ADC_W-1:0] v);
        lead_one = 0;
        for (int i = 0; i < ADC_W; i++) begin
            if (v[i]) lead_one = i;
        end
    endfunction

    logic [2:0]       mode_q;
    logic [ADC_W-1:0] run_min, run_max, act_min, act_max;
    logic             seen;

    logic [2:0]       mode_eff;
    logic [ADC_W-1:0] use_min, use_max, d_c, span_c;

    // A pixel on the frame-start cycle already sees the new mode and the
    // statistics that are being promoted that same cycle.
    assign mode_eff = frame_start ? mode : mode_q;
    assign use_min  = (frame_start && seen) ? run_min : act_min;
    assign use_max  = (frame_start && seen) ? run_max : act_max;
    assign d_c      = (data_in > use_min) ? data_in - use_min : '0;
    assign span_c   = (use_max > use_min) ? use_max - use_min : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= 3'b000;
            run_min <= '1;
            run_max <= '0;
            act_min <= '0;
            act_max <= '1;
            seen    <= 1'b0;
        end else if (frame_start) begin
            mode_q <= mode;
            if (seen) begin
                act_min <= run_min;
                act_max <= run_max;
            end
            if (data_valid) begin
                run_min <= data_in;
                run_max <= data_in;
                seen    <= 1'b1;
            end else begin
                run_min <= '1;
                run_max <= '0;
                seen    <= 1'b0;
            end
        end else if (data_valid) begin
            if (data_in < run_min) run_min <= data_in;
            if (data_in > run_max) run_max <= data_in;
            seen <= 1'b1;
        end
    end

    logic             s1_valid;
    logic [2:0]       s1_mode;
    logic [ADC_W-1:0] s1_data, s1_d, s1_span;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= 3'b000;
            s1_data  <= '0;
            s1_d     <= '0;
            s1_span  <= '0;
        end else begin
            s1_valid <= data_valid;
            s1_mode  <= mode_eff;
            s1_data  <= data_in;
            s1_d     <= d_c;
            s1_span  <= span_c;
        end
    end

    int                 shift_amt;
    logic [2*ADC_W-1:0] wide;
    logic [ADC_W-1:0]   norm_c;
    logic [LUT_AW-1:0]  rd_addr;

    // Shift so the span's leading one lands on the MSB; overflow saturates.
    always_comb begin
        shift_amt = ADC_W - 1 - lead_one(s1_span);
        wide      = {{ADC_W{1'b0}}, s1_d} << shift_amt;
        if (!s1_mode[MODE_AUTO] || s1_span == '0) begin
            norm_c = s1_data;
        end else if (|wide[2*ADC_W-1:ADC_W]) begin
            norm_c = '1;
        end else begin
            norm_c = wide[ADC_W-1:0];
        end
    end

    assign rd_addr = LUT_AW'(norm_c >> (ADC_W - LUT_AW));

    logic [3*VGA_W-1:0] pal_q;

    thermal_palette_ram #(
        .AW (LUT_AW),
        .DW (3*VGA_W)
    ) u_ram (
        .clk     (clk),
        .we      (pal_we),
        .wr_addr (pal_addr),
        .wr_data (pal_data),
        .rd_addr (rd_addr),
        .rd_data (pal_q)
    );

    logic             s2_valid;
    logic [1:0]       s2_mode;
    logic [VGA_W-1:0] s2_gray;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_mode  <= 2'b00;
            s2_gray  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode[1:0];
            s2_gray  <= VGA_W'(norm_c >> (ADC_W - VGA_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                case (colour_mode_e'(s2_mode))
                    MODE_GRAY: begin
                        red   <= s2_gray;
                        green <= s2_gray;
                        blue  <= s2_gray;
                    end
                    MODE_INV: begin
                        red   <= ~s2_gray;
                        green <= ~s2_gray;
                        blue  <= ~s2_gray;
                    end
                    MODE_PAL: begin
                        {red, green, blue} <= pal_q;
                    end
                    MODE_TEST: begin
                        red   <= '1;
                        green <= '0;
                        blue  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
